// File: rtl/key_pio_in_if.sv
// Avalon-MM slave bus bundle for the push-button input port.
interface key_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/key_pio_in.sv
// Push-button input port: per-bit sync + debounce, falling-edge capture,
// maskable level interrupt, Avalon-MM register access.
module key_pio_in #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  key_pio_in_if.slave      bus
);
  localparam int unsigned     CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned     DATA_W    = 32;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]      ADDR_DATA = 2'd0;
  localparam logic [1:0]      ADDR_MASK = 2'd2;
  localparam logic [1:0]      ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0]  s1, s2, stable, mask, edge_cap;
  logic [CNT_W-1:0]  cnt [WIDTH];
  logic [WIDTH-1:0]  differ_c, flip_c, fall_c, clr_c, edge_nxt_c;
  logic              wr_c;
  logic [DATA_W-1:0] rd_c;
  logic              unused_wdata;

  assign unused_wdata = ^bus.writedata;

  // A bit flips once it has disagreed with its stable value for DEBOUNCE_CYCLES samples.
  assign differ_c = s2 ^ stable;
  always_comb begin
    flip_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      flip_c[i] = differ_c[i] && (cnt[i] == CNT_LAST);
    end
  end

  // Only 1->0 flips (key press) set EDGE; the set dominates a same-cycle clear.
  assign fall_c     = flip_c & stable;
  assign wr_c       = bus.chipselect && !bus.write_n;
  assign clr_c      = (wr_c && (bus.address == ADDR_EDGE)) ? bus.writedata[WIDTH-1:0] : '0;
  assign edge_nxt_c = (edge_cap & ~clr_c) | fall_c;

  always_comb begin
    rd_c = '0;
    case (bus.address)
      ADDR_DATA: rd_c = DATA_W'(stable);
      ADDR_MASK: rd_c = DATA_W'(mask);
      ADDR_EDGE: rd_c = DATA_W'(edge_cap);
      default:   rd_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1           <= '1;
      s2           <= '1;
      stable       <= '1;
      mask         <= '0;
      edge_cap     <= '0;
      bus.readdata <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1           <= in_port;
      s2           <= s1;
      stable       <= stable ^ flip_c;
      edge_cap     <= edge_nxt_c;
      bus.readdata <= rd_c;
      if (wr_c && (bus.address == ADDR_MASK)) begin
        mask <= bus.writedata[WIDTH-1:0];
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= (differ_c[i] && !flip_c[i]) ? cnt[i] + CNT_W'(1) : '0;
      end
    end
  end

  assign bus.irq = |(edge_cap & mask);
endmodule

// File: tb/tb_key_pio_in.sv
// Randomised and directed checks of key_pio_in against a window-based reference model.
module tb_key_pio_in;
  localparam int unsigned W   = 4;
  localparam int unsigned DEB = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_port;
  int           n_checks = 0;
  int           n_fail   = 0;

  key_pio_in_if bus ();

  key_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] dly[$];    // raw samples still travelling through the synchroniser
  logic [W-1:0] hist[$];   // last DEB synchronised samples seen by the debouncer
  logic [W-1:0] m_stable, m_mask, m_edge;
  logic [31:0]  m_rd;
  logic         m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // A bit's stable level flips when its last DEB synchronised samples all disagree with it.
  task automatic model_edge();
    logic [W-1:0] used, fall, nxt;
    logic         all_diff;
    if (!reset_n) begin
      dly      = '{4'hF, 4'hF};
      hist     = {};
      m_stable = '1;
      m_mask   = '0;
      m_edge   = '0;
      m_rd     = '0;
    end else begin
      case (bus.address)
        2'd0:    m_rd = {28'h0, m_stable};
        2'd2:    m_rd = {28'h0, m_mask};
        2'd3:    m_rd = {28'h0, m_edge};
        default: m_rd = '0;
      endcase
      used = dly.pop_front();
      dly.push_back(in_port);
      hist.push_back(used);
      if (hist.size() > DEB) void'(hist.pop_front());
      nxt  = m_stable;
      fall = '0;
      for (int b = 0; b < W; b++) begin
        all_diff = (hist.size() == DEB);
        foreach (hist[k]) if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) begin
          nxt[b]  = ~m_stable[b];
          fall[b] = m_stable[b];
        end
      end
      if (bus.chipselect && !bus.write_n) begin
        if (bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
        if (bus.address == 2'd3) m_edge = m_edge & ~bus.writedata[W-1:0];
      end
      m_edge   = m_edge | fall;
      m_stable = nxt;
    end
    m_irq = |(m_edge & m_mask);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("readdata", bus.readdata, m_rd);
    check("irq", 32'(bus.irq), 32'(m_irq));
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    tick();
    bus_idle();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = a;
    tick();
    v = bus.readdata;
    bus_idle();
  endtask

  // Hold a read of EDGE; EDGE must be clear through edge DEB and set at edge 1+DEB.
  task automatic watch_edge(input string tag, input logic [31:0] exp_set);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = 2'd3;
    for (int e = 0; e <= 7; e++) begin
      tick();
      if (e == 1 + DEB) check({tag, "_early"}, bus.readdata, 32'h0);
      if (e == 2 + DEB) check({tag, "_set"}, bus.readdata, exp_set);
    end
    bus_idle();
  endtask

  logic [31:0] v;
  logic [31:0] mux_exp [4];

  initial begin
    bus_idle();
    reset_n = 1'b0;
    in_port = '0;
    dly     = '{4'hF, 4'hF};

    // Reset with all keys held, then the fresh presses are debounced
    idle(3);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", 32'(bus.irq), 32'h0);
    reset_n = 1'b1;
    watch_edge("rst_edge", 32'hF);
    rd(2'd0, v); check("held_data", v, 32'h0);
    in_port = 4'hF;
    idle(8);
    rd(2'd3, v); check("release_no_set", v, 32'hF);
    wr(2'd3, 32'hF);
    rd(2'd3, v); check("edge_cleared", v, 32'h0);
    rd(2'd0, v); check("released_data", v, 32'hF);

    // Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted
    in_port = 4'b1110; idle(3);
    in_port = 4'hF;    idle(10);
    rd(2'd0, v); check("glitch_data", v, 32'hF);
    rd(2'd3, v); check("glitch_edge", v, 32'h0);
    check("glitch_irq", 32'(bus.irq), 32'h0);
    in_port = 4'b1110; idle(4);
    in_port = 4'hF;    idle(10);
    rd(2'd3, v); check("pulse4_edge", v, 32'h1);
    rd(2'd0, v); check("pulse4_data", v, 32'hF);
    wr(2'd3, 32'hF);

    // Masked interrupt
    wr(2'd2, 32'h4);
    in_port = 4'b1101; idle(8);
    rd(2'd3, v); check("mask_edge2", v, 32'h2);
    check("mask_irq_off", 32'(bus.irq), 32'h0);
    in_port = 4'b1001;
    for (int e = 0; e <= 1 + DEB; e++) begin
      tick();
      if (e == DEB)     check("irq_before", 32'(bus.irq), 32'h0);
      if (e == 1 + DEB) check("irq_rise", 32'(bus.irq), 32'h1);
    end
    rd(2'd3, v); check("mask_edge6", v, 32'h6);

    // Write-1-to-clear
    wr(2'd3, 32'h4);
    check("w1c_irq", 32'(bus.irq), 32'h0);
    rd(2'd3, v); check("w1c_edge", v, 32'h2);
    wr(2'd3, 32'h0);
    rd(2'd3, v); check("w0_edge", v, 32'h2);
    in_port = 4'hF; idle(8);
    rd(2'd3, v); check("rise_no_set", v, 32'h2);
    wr(2'd3, 32'hF);

    // Set/clear collision: clear write lands on the flip edge of bit 3
    wr(2'd2, 32'h8);
    in_port = 4'b0111; idle(1 + DEB);
    wr(2'd3, 32'h8);
    rd(2'd3, v); check("collide_edge", v, 32'h8);
    check("collide_irq", 32'(bus.irq), 32'h1);
    in_port = 4'hF; idle(8);
    wr(2'd3, 32'hF);

    // Back-to-back read mux
    wr(2'd2, 32'h5);
    mux_exp = '{32'hF, 32'h0, 32'h5, 32'h0};
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.address = 2'(k);
      tick();
      check("read_mux", bus.readdata, mux_exp[k]);
    end
    bus_idle();

    // Reset part way through a debounce (count at 2) discards it
    in_port = 4'b1110; idle(4);
    reset_n = 1'b0; tick();
    check("mid_rst_readdata", bus.readdata, 32'h0);
    check("mid_rst_irq", 32'(bus.irq), 32'h0);
    reset_n = 1'b1;
    watch_edge("redebounce", 32'h1);
    rd(2'd2, v); check("mid_rst_mask", v, 32'h0);
    in_port = 4'hF; idle(8);
    wr(2'd3, 32'hF);

    // Randomised traffic with held key levels of varied length
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) in_port[$urandom_range(W - 1)] ^= 1'b1;
      reset_n        = ($urandom_range(399) != 0);
      bus.chipselect = $urandom_range(1) == 1;
      bus.write_n    = $urandom_range(3) != 0;
      bus.address    = 2'($urandom_range(3));
      bus.writedata  = $urandom();
      tick();
    end
    bus_idle();
    reset_n = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
